// File: rtl/alu_seq.sv
// Execute-stage sequencer in front of the core's single combinational ALU.
// Subtraction is folded into ADD, and shifts can be run one bit per cycle.
module alu_seq #(
    parameter int XLEN         = 32,
    parameter bit SERIAL_SHIFT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [4:0]      in_rd,
    output logic            alu_en,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy
);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    state_t accept_target;

    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [4:0]      rd_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] data_q;

    logic            accept;
    logic [XLEN-1:0] b_in;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SRA);
    endfunction

    // Both ports use plain valid/ready: a transfer happens on the rising edge
    // where valid and ready are both high; the producer holds its payload
    // stable while valid is high and ready is low.
    assign accept = in_valid && in_ready;
    assign b_in   = in_use_imm ? in_imm : in_rs2_val;

    always_comb begin
        accept_target = EXEC;
        if (!is_legal(in_op)) begin
            accept_target = IDLE;
        end else if (SERIAL_SHIFT && is_shift(in_op)) begin
            accept_target = (b_in[4:0] == 5'd0) ? WB : SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = accept_target;
                end
            end
            EXEC: begin
                state_next = WB;
            end
            SHIFT: begin
                if (cnt_q == 5'd1) begin
                    state_next = WB;
                end
            end
            WB: begin
                // Retiring and accepting may coincide on the same edge.
                if (wb_ready) begin
                    state_next = accept ? accept_target : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q  <= in_op;
            a_q   <= in_rs1_val;
            b_q   <= b_in;
            rd_q  <= in_rd;
            cnt_q <= b_in[4:0];
            acc_q <= in_rs1_val;
            if (accept_target == WB) begin
                data_q <= in_rs1_val;
            end
        end else if (state == EXEC) begin
            data_q <= alu_result;
        end else if (state == SHIFT) begin
            acc_q <= alu_result;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                data_q <= alu_result;
            end
        end
    end

    always_comb begin
        in_ready = rst_n && ((state == IDLE) || ((state == WB) && wb_ready));
        busy     = (state != IDLE);
        alu_en   = 1'b0;
        alu_op   = '0;
        alu_a    = '0;
        alu_b    = '0;
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        case (state)
            EXEC: begin
                alu_en = 1'b1;
                alu_a  = a_q;
                if (op_q == OP_SUB) begin
                    alu_op = OP_ADD;
                    alu_b  = (~b_q) + {{(XLEN-1){1'b0}}, 1'b1};
                end else if (is_shift(op_q)) begin
                    alu_op = op_q;
                    alu_b  = {{(XLEN-5){1'b0}}, b_q[4:0]};
                end else begin
                    alu_op = op_q;
                    alu_b  = b_q;
                end
            end
            SHIFT: begin
                alu_en = 1'b1;
                alu_op = op_q;
                alu_a  = acc_q;
                alu_b  = {{(XLEN-1){1'b0}}, 1'b1};
            end
            WB: begin
                wb_valid = 1'b1;
                wb_rd    = rd_q;
                wb_data  = (rd_q == 5'd0) ? '0 : data_q;
            end
            default: begin
            end
        endcase
    end

endmodule
